// File: rtl/lzrw1_group_packer.sv
// LZRW1 group packer: collects up to GROUPITEMS literal/copy items, then streams
// the 16-bit little-endian control word followed by the buffered item bytes.
module lzrw1_group_packer #(
    parameter int GROUPITEMS = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_copy,
    input  logic [7:0]  in_literal,
    input  logic [11:0] in_offset,
    input  logic [3:0]  in_length,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_byte,
    output logic        out_last,
    output logic [15:0] group_count,
    output logic        err
);

    localparam int DEPTH = 2 * GROUPITEMS;
    localparam int AW    = $clog2(DEPTH);
    localparam int BW    = AW + 1;
    localparam int IW    = $clog2(GROUPITEMS + 1);
    localparam logic [IW-1:0] LASTITEM = IW'(GROUPITEMS - 1);

    typedef enum logic [1:0] {FILL, CTRL_LO, CTRL_HI, ITEMS} stateType;

    stateType       state, stateNext;
    logic [IW-1:0]  itemCnt;
    logic [BW-1:0]  byteCnt;
    logic [BW-1:0]  rdPtr;
    logic [15:0]    control;
    logic [15:0]    ctrlSet;
    logic           lastGrp;
    logic [7:0]     buffer [DEPTH];
    logic [AW-1:0]  wrIdx;

    logic accept, outFire, closing, finalByte, illegal;

    assign in_ready  = (state == FILL);
    assign out_valid = (state != FILL);
    assign wrIdx     = byteCnt[AW-1:0];

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        accept    = in_valid && in_ready;
        outFire   = out_valid && out_ready;
        closing   = accept && (in_last || itemCnt == LASTITEM);
        finalByte = (state == ITEMS) && (rdPtr == byteCnt);
        illegal   = in_copy && (in_length < 4'd2 || in_offset == 12'd0);
        ctrlSet   = control | (16'(in_copy) << itemCnt);
        stateNext = state;
        case (state)
            FILL:    if (closing)              stateNext = CTRL_LO;
            CTRL_LO: if (outFire)              stateNext = CTRL_HI;
            CTRL_HI: if (outFire)              stateNext = ITEMS;
            ITEMS:   if (outFire && finalByte) stateNext = FILL;
            default:                           stateNext = FILL;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= FILL;
        else        state <= stateNext;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            itemCnt     <= '0;
            byteCnt     <= '0;
            rdPtr       <= '0;
            control     <= '0;
            lastGrp     <= 1'b0;
            out_byte    <= '0;
            out_last    <= 1'b0;
            group_count <= '0;
            err         <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (accept) begin
                        control <= ctrlSet;
                        itemCnt <= itemCnt + IW'(1);
                        byteCnt <= byteCnt + (in_copy ? BW'(2) : BW'(1));
                        if (illegal) err <= 1'b1;
                    end
                    // The control low byte already includes the closing item's bit.
                    if (closing) begin
                        lastGrp  <= in_last;
                        out_byte <= ctrlSet[7:0];
                        out_last <= 1'b0;
                    end
                end
                CTRL_LO: begin
                    if (outFire) out_byte <= control[15:8];
                end
                CTRL_HI: begin
                    if (outFire) begin
                        out_byte <= buffer[0];
                        out_last <= lastGrp && (byteCnt == BW'(1));
                        rdPtr    <= BW'(1);
                    end
                end
                ITEMS: begin
                    if (outFire) begin
                        if (finalByte) begin
                            group_count <= group_count + 16'd1;
                            itemCnt     <= '0;
                            byteCnt     <= '0;
                            rdPtr       <= '0;
                            control     <= '0;
                            lastGrp     <= 1'b0;
                            out_byte    <= '0;
                            out_last    <= 1'b0;
                        end else begin
                            out_byte <= buffer[rdPtr[AW-1:0]];
                            out_last <= lastGrp && (rdPtr == byteCnt - BW'(1));
                            rdPtr    <= rdPtr + BW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: the byte buffer has no reset; byteCnt alone decides which entries are live.
    always_ff @(posedge clock) begin
        if (accept) begin
            if (in_copy) begin
                buffer[wrIdx]          <= {in_offset[11:8], in_length};
                buffer[wrIdx + AW'(1)] <= in_offset[7:0];
            end else begin
                buffer[wrIdx] <= in_literal;
            end
        end
    end

endmodule

// File: doc/lzrw1_group_packer.md
# lzrw1_group_packer

Downstream neighbour of the LZRW1 compressor core. It consumes one compressed item per handshake: a literal byte, or a copy item with a 12-bit offset and a 4-bit length. It packs up to 16 items into an LZRW1 group and emits the group as a byte stream: a 16-bit control word (little-endian) followed by the item bytes. The block turns the core's per-item literal/offset/length/ControlBit results into the serial output format written to memory.

## Interface
Parameters:
- GROUPITEMS, 16, items per group; sets the control-word width and the buffer depth (2*GROUPITEMS bytes).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  an item is presented.
- in_ready  out  1  packer accepts items; high only in FILL.
- in_copy  in  1  the item's ControlBit: 1 = copy item, 0 = literal.
- in_literal  in  8  literal byte; used when in_copy=0.
- in_offset  in  12  copy offset; used when in_copy=1.
- in_length  in  4  copy length code = match length − 1; legal range 2..15.
- in_last  in  1  item is the final item of the string.
- out_valid  out  1  out_byte is valid.
- out_ready  in  1  sink accepts the byte.
- out_byte  out  8  packed stream byte.
- out_last  out  1  final byte of the final group of a string.
- group_count  out  16  number of completed groups emitted.
- err  out  1  sticky; a copy item had in_length<2 or in_offset==0.

## Operation
- FSM states: FILL, CTRL_LO, CTRL_HI, ITEMS.
- FILL: in_ready=1. On each accept (in_valid && in_ready):
  - Control bit [item_cnt] is set to in_copy.
  - A literal writes 1 buffer byte: in_literal.
  - A copy writes 2 buffer bytes: {in_offset[11:8], in_length}, then in_offset[7:0].
  - item_cnt and byte_cnt are incremented.
- Group close: accepting item number GROUPITEMS, or any item with in_last=1, moves FILL→CTRL_LO. A closing in_last sets an internal last_grp flag.
- CTRL_LO emits control[7:0], then CTRL_HI emits control[15:8]. Each byte holds until its handshake.
- ITEMS emits buffer bytes 0..byte_cnt−1 in order.
- On the handshake of the final item byte:
  - group_count is incremented (wraps 0xFFFF→0).
  - item_cnt, byte_cnt, control and last_grp are cleared.
  - The FSM returns to FILL.
- Control bits for unused item slots in a partial group are 0.
- out_last=1 only on the final item byte when last_grp=1.
- Illegal copy items set err and are still packed exactly as given. err clears only on reset.
- in_last with in_valid=0 is ignored. Every group holds at least 1 item.

## Timing
- Reset value of every output is 0, except in_ready=1 (state FILL). Inputs are ignored while reset is low.
- Reset asserted mid-group or mid-emission:
  - out_valid falls immediately.
  - Buffered data is discarded and counters and err are cleared.
  - The FSM is in FILL on the first edge after release.
- out_byte and out_last are registered outputs. out_valid rises the cycle after the closing item is accepted.
- While out_valid && !out_ready, out_byte and out_last hold stable. There are no bubbles between bytes while out_ready=1.
- in_ready is low from the cycle after the close until the cycle after the final item-byte handshake. The next item can be accepted that cycle.
- Group of B item bytes: 2+B output handshakes. 16 literals take 18 bytes; 16 copies take 34 bytes (buffer full, 32 bytes).
- The control bit for an item is bit index item_cnt. The first item is bit 0 of control[7:0].

## Test plan
- 16 literals 0x41..0x50 with out_ready=1 → 0x00, 0x00, 0x41..0x50 on 18 consecutive cycles; out_last=0; group_count=1; in_ready low for 18 cycles.
- Copy (offset 0x123, length 0x5) followed by 15 literals 0x30 → 0x01, 0x00, 0x15, 0x23, then 15×0x30; err=0.
- Partial final group:
  - Input: lit 0x61, copy (offset 0xABC, length 0xF), lit 0x62 with in_last=1.
  - Expected: 0x02, 0x00, 0x61, 0xAF, 0xBC, 0x62, with out_last=1 only on 0x62.
  - Then FILL, group_count=1.
- 16 copies (offset 0x001..0x010, length 0x2) → 0xFF, 0xFF, then 32 bytes 0x02, 0x01, 0x02, 0x02, …, 0x02, 0x10; no overflow.
- Random out_ready toggling over 50 groups → byte stream identical to the out_ready=1 run; out_byte stable whenever stalled.
- Backpressure, reset and error:
  - Copy with length 0x1 → err=1 and stays set.
  - Reset pulse during CTRL_HI → out_valid, err and group_count go to 0 at once; in_ready=1; the next group packs cleanly.
